// File: rtl/gru_seq_ctrl_pkg.sv
// rtl/gru_seq_ctrl_pkg.sv - shared sizes, state codes and helpers for the GRU sequencer
package gru_pkg;

  localparam int INPUTDIMEN = 4;
  localparam int CELLNUM    = 4;
  localparam int DATABIT    = 16;
  localparam int STEP       = 10;
  localparam int TIMEOUT    = 64;

  localparam int XTNUM = INPUTDIMEN * DATABIT;
  localparam int HTNUM = CELLNUM * DATABIT;
  localparam int STEPW = 4;
  localparam int WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef logic [STEPW-1:0] step_idx_t;
  typedef logic [2:0]       gru_state_t;

  localparam gru_state_t ST_IDLE  = 3'd0;
  localparam gru_state_t ST_FILL  = 3'd1;
  localparam gru_state_t ST_ISSUE = 3'd2;
  localparam gru_state_t ST_WAIT  = 3'd3;
  localparam gru_state_t ST_EMIT  = 3'd4;
  localparam gru_state_t ST_FIN   = 3'd5;

  // True when an index addresses the final frame / time step of a sequence.
  function automatic logic is_last(input step_idx_t idx);
    return int'(idx) == STEP - 1;
  endfunction

endpackage

// File: rtl/gru_seq_ctrl_if.sv
// rtl/gru_seq_ctrl_if.sv - input stream, layer drive and hidden-state output bundle
interface gru_seq_ctrl_if;
  import gru_pkg::*;

  logic             start;
  logic             x_valid;
  logic             x_ready;
  logic [XTNUM-1:0] x_data;
  logic             layer_en;
  logic [XTNUM-1:0] layer_xt;
  logic             layer_result_valid;
  logic [HTNUM-1:0] layer_h;
  logic             h_valid;
  logic             h_ready;
  logic [HTNUM-1:0] h_data;
  logic [3:0]       h_step;
  logic             busy;
  logic             done;
  logic             err_timeout;

  // Sequencer side.
  modport master (
    input  start, x_valid, x_data, layer_result_valid, layer_h, h_ready,
    output x_ready, layer_en, layer_xt, h_valid, h_data, h_step, busy, done, err_timeout
  );

  // Host / layer / downstream side.
  modport slave (
    output start, x_valid, x_data, layer_result_valid, layer_h, h_ready,
    input  x_ready, layer_en, layer_xt, h_valid, h_data, h_step, busy, done, err_timeout
  );

endinterface

// File: rtl/gru_seq_ctrl_xt_buf.sv
// rtl/gru_seq_ctrl_xt_buf.sv - STEP-deep input frame buffer, registered write, combinational read
module gru_xt_buf
  import gru_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  step_idx_t        waddr,
  input  logic [XTNUM-1:0] wdata,
  input  step_idx_t        raddr,
  output logic [XTNUM-1:0] rdata
);

  logic [XTNUM-1:0] mem_q [STEP];

  // Frame storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (we && int'(waddr) < STEP) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < STEP) ? mem_q[raddr] : '0;

endmodule

// File: rtl/gru_seq_ctrl.sv
// rtl/gru_seq_ctrl.sv - GRU hidden-layer sequencer top (GRU_SEQ_LAST_ONLY_EN: emit final step only)
module gru_seq_ctrl
  import gru_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  gru_seq_ctrl_if.master bus
);

  gru_state_t       state_q, state_d;
  step_idx_t        cnt_q, cnt_d;
  step_idx_t        step_q, step_d;
  step_idx_t        hstep_q, hstep_d;
  logic [WAITW-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic             rv_q;
  logic [XTNUM-1:0] xt_q, xt_d, buf_rdata;
  logic [HTNUM-1:0] h_q, h_d;
  logic             buf_we;
  logic             rv_edge;

  // A result level carried over from the previous step is not a new result.
  assign rv_edge = bus.layer_result_valid & ~rv_q;

  gru_xt_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q),
    .wdata (bus.x_data),
    .raddr (step_d),
    .rdata (buf_rdata)
  );

  // The frame for a new step is latched on ISSUE entry; for STEP==1 it may still be in flight.
  assign xt_d = (buf_we && (cnt_q == step_d)) ? bus.x_data : buf_rdata;

  // Next-state and datapath update decisions for the sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    hstep_d = hstep_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    h_d     = h_q;
    buf_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          step_d  = '0;
          wcnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_FILL: begin
        if (bus.x_valid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (is_last(cnt_q)) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        wcnt_d  = '0;
      end
      ST_WAIT: begin
        if (rv_edge) begin
          h_d     = bus.layer_h;
          hstep_d = step_q;
`ifdef GRU_SEQ_LAST_ONLY_EN
          if (is_last(step_q)) begin
            state_d = ST_EMIT;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_EMIT;
`endif
        end else if (wcnt_q == WAITW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (bus.h_ready) begin
          if (is_last(step_q)) begin
            state_d = ST_FIN;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, counters and the previous result_valid sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      rv_q    <= bus.layer_result_valid;
    end
  end

  // Held data toward the layer and the downstream consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xt_q    <= '0;
      h_q     <= '0;
      hstep_q <= '0;
    end else begin
      if (state_d == ST_ISSUE) begin
        xt_q <= xt_d;
      end
      h_q     <= h_d;
      hstep_q <= hstep_d;
    end
  end

  assign bus.x_ready     = (state_q == ST_FILL);
  assign bus.layer_en    = (state_q == ST_ISSUE);
  assign bus.layer_xt    = xt_q;
  assign bus.h_valid     = (state_q == ST_EMIT);
  assign bus.h_data      = h_q;
  assign bus.h_step      = hstep_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_FIN);
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// tb/tb_gru_seq_ctrl.sv - randomized scoreboard bench for gru_seq_ctrl
module tb_gru_seq_ctrl;
  import gru_pkg::*;

  localparam int CW = 64;
`ifdef GRU_SEQ_LAST_ONLY_EN
  localparam bit LAST_ONLY = 1'b1;
`else
  localparam bit LAST_ONLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gru_seq_ctrl_if bus ();
  gru_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]       step;
    logic [HTNUM-1:0] h;
  } beat_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  beat_t            exp_q[$];
  logic [XTNUM-1:0] frames[STEP];
  logic [HTNUM-1:0] hvals[STEP];

  int lat_min = 2, lat_max = 30;
  bit hold_mode = 1'b0;
  bit hr_rand = 1'b0;
  int mute_step = -1, bp_step = -1, bp_cnt = 0;
  int en_cnt = 0, edge_at = -1, drop_at = -1, edge_step = 0, mute_en_cyc = -1;
  int hv_due = -1, en_due = -1;
  int beats = 0, x_hs = 0, dones = 0, last_done_cyc = -10;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    chk("reset_ctrl_outputs", CW'({bus.busy, bus.done, bus.x_ready, bus.layer_en,
                                   bus.h_valid, bus.err_timeout, bus.h_step}), '0);
    chk("reset_h_data", CW'(bus.h_data), '0);
    chk("reset_layer_xt", CW'(bus.layer_xt), '0);
  endtask

  // Layer model: after each layer_en, raise result_valid a random latency later with the step's h.
  initial begin : layer_model
    int   s;
    beat_t b;
    bus.layer_result_valid = 1'b0;
    bus.layer_h = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.layer_result_valid = 1'b0;
        edge_at = -1;
        drop_at = -1;
      end else begin
        if (bus.layer_en) begin
          s = en_cnt;
          en_cnt++;
          if (s >= STEP) begin
            chk("extra_layer_en", CW'(s), CW'(STEP - 1));
          end else begin
            chk("layer_xt_at_issue", CW'(bus.layer_xt), CW'(frames[s]));
            if (s == mute_step) begin
              mute_en_cyc = cyc;
            end else begin
              edge_at = cyc + int'($urandom_range(lat_max, lat_min));
              edge_step = s;
            end
          end
        end
        if (cyc == edge_at - 1 || cyc == drop_at) bus.layer_result_valid = 1'b0;
        if (cyc == edge_at) begin
          bus.layer_result_valid = 1'b1;
          bus.layer_h = hvals[edge_step];
          chk("layer_xt_held", CW'(bus.layer_xt), CW'(frames[edge_step]));
          if (!hold_mode) drop_at = cyc + 2;
          if (!LAST_ONLY || edge_step == STEP - 1) begin
            b.step = 4'(edge_step);
            b.h = hvals[edge_step];
            exp_q.push_back(b);
            hv_due = cyc + 1;
          end else begin
            en_due = cyc + 1;
          end
        end
      end
    end
  end

  // Downstream consumer: random or constant ready, with an optional 30-cycle stall on one step.
  initial begin : h_sink
    bus.h_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_step >= 0 && bus.h_valid && int'(bus.h_step) == bp_step && bp_cnt < 30) begin
        bus.h_ready = 1'b0;
        bp_cnt++;
      end else begin
        bus.h_ready = hr_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops, latency, stability and end-of-sequence checks.
  initial begin : monitor
    beat_t            b;
    bit               hold_chk;
    logic [HTNUM-1:0] hold_h;
    logic [3:0]       hold_step;
    hold_chk = 1'b0;
    hold_h = '0;
    hold_step = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_chk = 1'b0;
      end else begin
        if (hv_due == cyc) chk("h_valid_latency", CW'(bus.h_valid), 1);
        if (en_due == cyc) chk("layer_en_latency", CW'(bus.layer_en), 1);
        if (bus.h_valid) chk("no_issue_while_emitting", CW'(bus.layer_en), 0);
        if (hold_chk) begin
          chk("h_valid_held", CW'(bus.h_valid), 1);
          chk("h_data_held", CW'(bus.h_data), CW'(hold_h));
          chk("h_step_held", CW'(bus.h_step), CW'(hold_step));
        end
        hold_chk = bus.h_valid && !bus.h_ready;
        hold_h = bus.h_data;
        hold_step = bus.h_step;
        if (bus.h_valid && bus.h_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            chk("unexpected_h_beat", CW'(bus.h_step), '1);
          end else begin
            b = exp_q.pop_front();
            chk("h_step", CW'(bus.h_step), CW'(b.step));
            chk("h_data", CW'(bus.h_data), CW'(b.h));
            if (!LAST_ONLY && int'(bus.h_step) < STEP - 1) en_due = cyc + 1;
          end
        end
        if (bus.x_valid && bus.x_ready) begin
          x_hs++;
          if (x_hs == STEP) en_due = cyc + 1;
        end
        if (bus.done) begin
          chk("done_one_cycle", CW'(cyc - last_done_cyc > 1), 1);
          dones++;
          last_done_cyc = cyc;
          if (mute_en_cyc >= 0) begin
            chk("timeout_cycle", CW'(cyc), CW'(mute_en_cyc + TIMEOUT + 1));
            chk("err_timeout_set", CW'(bus.err_timeout), 1);
          end else begin
            chk("err_timeout_clear", CW'(bus.err_timeout), 0);
          end
        end
      end
    end
  end

  task automatic run_seq(input bit nominal, input bit toggle, input int mute, input int bp,
                         input bit hold, input int abort_step, input bit spam);
    int fi, budget, d0, ab, exp_beats;
    for (int i = 0; i < STEP; i++) begin
      for (int e = 0; e < INPUTDIMEN; e++)
        frames[i][e*DATABIT +: DATABIT] = nominal ? DATABIT'(i + 1) : DATABIT'($urandom);
      for (int e = 0; e < CELLNUM; e++)
        hvals[i][e*DATABIT +: DATABIT] = nominal ? DATABIT'(i * 257) : DATABIT'($urandom);
    end
    lat_min = nominal ? 22 : ((abort_step >= 0) ? 10 : 2);
    lat_max = nominal ? 22 : 30;
    hold_mode = hold;
    mute_step = mute;
    bp_step = bp;
    bp_cnt = 0;
    hr_rand = !nominal && bp < 0;
    mute_en_cyc = -1;
    en_cnt = 0;
    edge_at = -1;
    drop_at = -1;
    hv_due = -1;
    en_due = -1;
    beats = 0;
    x_hs = 0;
    d0 = dones;
    exp_q.delete();

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.x_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", CW'(bus.busy), 1);
    chk("err_cleared_by_start", CW'(bus.err_timeout), 0);

    fi = 0;
    budget = 0;
    while (fi < STEP && budget < 200) begin
      @(posedge clk); #1;
      budget++;
      bus.x_valid = toggle ? budget[0] : (nominal || $urandom_range(3, 0) != 0);
      bus.x_data = frames[fi];
      @(negedge clk);
      if (bus.x_valid && bus.x_ready) fi++;
    end
    chk("frames_sent_in_budget", CW'(fi), CW'(STEP));

    budget = 0;
    ab = 0;
    while (dones == d0 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      bus.x_valid = toggle;
      bus.x_data = {$urandom, $urandom};
      bus.start = spam && en_cnt < STEP - 1 && $urandom_range(7, 0) == 0;
      if (abort_step >= 0 && en_cnt == abort_step + 1) ab++;
      if (ab == 6) begin
        bus.start = 1'b0;
        bus.x_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        chk("beats_before_abort", CW'(beats), CW'(LAST_ONLY ? 0 : abort_step));
        exp_q.delete();
        hv_due = -1;
        en_due = -1;
        edge_at = -1;
        drop_at = -1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.x_valid = 1'b0;
    chk("done_seen", CW'(dones - d0), 1);
    chk("frames_accepted", CW'(x_hs), CW'(STEP));
    chk("scoreboard_drained", CW'(exp_q.size()), 0);
    exp_beats = (mute >= 0) ? (LAST_ONLY ? 0 : mute) : (LAST_ONLY ? 1 : STEP);
    chk("h_beat_count", CW'(beats), CW'(exp_beats));
`ifndef GRU_SEQ_LAST_ONLY_EN
    if (bp >= 0) chk("bp_stall_cycles", CW'(bp_cnt), 30);
`endif
    @(negedge clk);
    chk("idle_after_done", CW'({bus.busy, bus.done}), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.start = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_seq(1'b1, 1'b0, -1, -1, 1'b0, -1, 1'b1);  // nominal, start ignored while busy
    run_seq(1'b0, 1'b1, -1, -1, 1'b0, -1, 1'b0);  // input toggling, extra frames offered
    run_seq(1'b0, 1'b0, -1, 3, 1'b0, -1, 1'b0);   // output stall on step 3
    run_seq(1'b0, 1'b0, 2, -1, 1'b0, -1, 1'b0);   // layer silent on step 2
    @(negedge clk);
    chk("err_timeout_sticky", CW'(bus.err_timeout), 1);
    run_seq(1'b0, 1'b0, -1, -1, 1'b1, -1, 1'b0);  // result_valid held between steps
    run_seq(1'b0, 1'b0, -1, -1, 1'b0, 5, 1'b0);   // reset mid-WAIT at step 5
    run_seq(1'b0, 1'b0, -1, -1, 1'b0, -1, 1'b0);  // clean run after abort
    for (int r = 0; r < 2; r++)
      run_seq(1'b0, 1'($urandom_range(1, 0)), -1, -1, 1'($urandom_range(1, 0)), -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gru_seq_ctrl.md
Name: gru_seq_ctrl

Overview:
- Sequencer on the driving side of the GRU hidden-layer interface.
- Accepts a STEP-long sequence of input frames over a valid/ready stream and buffers it.
- Issues one frame per time step to the layer (xt plus a one-cycle enable), waits for the layer's result_valid, captures h and streams it out with a step index.
- Sits between the host/DMA input stream and the hidden layer; one instance per layer.

Parameters:
- INPUTDIMEN, 4, elements per input frame
- CELLNUM, 4, hidden cells (h width = CELLNUM*DATABIT)
- DATABIT, 16, bits per signed fixed-point element
- STEP, 10, time steps per sequence (>=1, <=16)
- TIMEOUT, 64, max cycles to wait for layer result before abort

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- x_valid  in  1  input frame valid
- x_ready  out  1  controller can take a frame
- x_data  in  INPUTDIMEN*DATABIT  input frame
- layer_en  out  1  one-cycle pulse: layer starts step computation
- layer_xt  out  INPUTDIMEN*DATABIT  frame for current step, stable from layer_en until capture
- layer_result_valid  in  1  layer output valid (level)
- layer_h  in  CELLNUM*DATABIT  layer hidden state
- h_valid  out  1  captured hidden state available
- h_ready  in  1  downstream accepts h
- h_data  out  CELLNUM*DATABIT  captured hidden state
- h_step  out  4  step index of h_data (0..STEP-1)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at sequence end
- err_timeout  out  1  sticky; cleared by next accepted start or reset

Behaviour:
- Reset: all outputs 0; state IDLE; frame count, step index, wait counter 0; h_data 0.
- States: IDLE, FILL, ISSUE, WAIT, EMIT, FIN.
- IDLE: start=1 -> FILL; clear err_timeout and counters.
- FILL: x_ready=1. Each x_valid&x_ready cycle writes x_data to buffer[count], count++. The handshake with count==STEP-1 -> ISSUE. x_ready=0 in all other states; x_valid there is ignored.
- ISSUE: layer_en=1 for exactly one cycle; layer_xt=buffer[step] (registered, driven from ISSUE through WAIT). -> WAIT; wait counter cleared.
- WAIT: capture on rising edge of layer_result_valid (prev sample 0, current 1). A level held high from the previous step is not a new result.
  - On capture: h_data<=layer_h, h_step<=step, -> EMIT.
  - Otherwise counter++. At counter==TIMEOUT-1 with no edge: err_timeout<=1, -> FIN.
- EMIT: h_valid=1; h_data/h_step held stable until h_ready.
  - On h_valid&h_ready: if step==STEP-1 -> FIN, else step++ and -> ISSUE.
  - Backpressure may stall indefinitely; no timeout in EMIT.
- FIN: done=1 for one cycle -> IDLE.
- Latency: layer_en occurs 1 cycle after the last frame handshake, and 1 cycle after each h handshake. h_valid occurs 1 cycle after the result_valid edge.
- start while busy is ignored. Reset mid-sequence aborts immediately: buffer contents are don't-care, outputs return to reset values.
- Simultaneous result edge and timeout terminal cycle: capture wins, no error.
- STEP==1: single ISSUE/WAIT/EMIT, then FIN.

Optional Feature:
- Macro GRU_SEQ_LAST_ONLY_EN.
- Defined: EMIT is entered only for step STEP-1. Intermediate steps go WAIT -> ISSUE directly on capture, and h_valid never asserts for them.
- Undefined: every step is emitted as above.

Decomposition:
- Shared package gru_pkg: INPUTDIMEN, CELLNUM, DATABIT, STEP and derived XTNUM/HTNUM widths, the state enum, and the step index width.
- Sub-module gru_xt_buf: STEP-deep, XTNUM-wide register buffer with write port (we, waddr, wdata) and combinational read port (raddr -> rdata).

Test Plan:
- Nominal: start, 10 frames 0x0001..0x000A replicated across elements; layer model raises result_valid 22 cycles after each layer_en with h=step*0x0101 -> 10 h beats, h_step 0..9, h_data matches, done pulses once, err_timeout 0.
- Input backpressure: x_valid toggles every other cycle -> exactly 10 frames accepted; layer_en one cycle after the 10th; x_ready 0 thereafter.
- Output backpressure: h_ready low 30 cycles on step 3 -> h_data/h_step stable, no layer_en until handshake, then step 4 issued next cycle.
- Timeout: layer model never responds on step 2 -> err_timeout=1 at cycle 64 of WAIT, done pulse, return to IDLE; a new start clears err_timeout.
- Level-held result_valid: model holds result_valid high across steps, drops 1 cycle before the next edge -> each step captured exactly once, no double beats.
- Reset mid-WAIT at step 5 -> all outputs 0 next cycle; a new start runs the full 10-step sequence cleanly (with GRU_SEQ_LAST_ONLY_EN: a single h beat, h_step=9).
